// File: rtl/header_detacher_pkg.sv
// Shared definitions for the Time Tagger header detacher: FSM states,
// header field positions and the header length in beats.
package header_detacher_pkg;

  typedef enum logic [0:0] {
    HEADER  = 1'b0,
    PAYLOAD = 1'b1
  } state_e;

  // Position of the 32-bit rollover time inside the 128-bit header beat
  localparam int ROLLOVER_LSB = 64;
  localparam int ROLLOVER_MSB = 95;

  // Every packet starts with exactly one header beat
  localparam int HDR_BEATS = 1;

  function automatic logic [ROLLOVER_MSB-ROLLOVER_LSB:0] rollover_of(input logic [127:0] hdr);
    return hdr[ROLLOVER_MSB:ROLLOVER_LSB];
  endfunction

endpackage

// File: rtl/header_detacher_skid.sv
// Two-entry AXI-Stream skid buffer used on the output side of the header
// detacher when HEADER_DETACHER_OUT_REG_EN is defined. The upstream ready is
// a pure register output, so no combinational path runs from m_ready back to
// s_ready, and a full main register plus an empty skid register still allows
// one beat per cycle.
`ifdef HEADER_DETACHER_OUT_REG_EN
module axis_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
);

  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             main_valid_q;
  logic             skid_valid_q;
  logic             push;
  logic             load_main;

  assign s_ready   = !skid_valid_q;
  assign push      = s_valid && !skid_valid_q;
  assign load_main = m_ready || !main_valid_q;
  assign m_valid   = main_valid_q;
  assign m_data    = main_q;

  // Main register refills from the skid entry first, then from the input; a
  // beat arriving while main is stalled parks in the skid entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (load_main) begin
      if (skid_valid_q) begin
        main_q       <= skid_q;
        main_valid_q <= 1'b1;
        skid_valid_q <= 1'b0;
      end else begin
        main_valid_q <= push;
        if (push) begin
          main_q <= s_data;
        end
      end
    end else if (push) begin
      skid_q       <= s_data;
      skid_valid_q <= 1'b1;
    end
  end

endmodule
`endif

// File: rtl/header_detacher.sv
// Strips the single 128-bit header beat from each Time Tagger packet,
// forwards the payload beats and presents the header's rollover time on
// m_axis_tuser for every payload beat of that packet.
// Optional build macro: HEADER_DETACHER_OUT_REG_EN registers the output
// through a 2-entry skid buffer (one extra cycle of payload latency).
module header_detacher
  import header_detacher_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int KEEP_WIDTH = (DATA_WIDTH + 7) / 8,
  parameter int USER_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic                  header_only
);

  if (DATA_WIDTH != 128 || HDR_BEATS != 1) begin : g_bad_config
    $error("header_detacher supports only DATA_WIDTH = 128 with a single header beat");
  end

  state_e                state;
  logic [USER_WIDTH-1:0] tuser_q;
  logic                  in_payload;
  logic                  hdr_hs;
  logic                  pay_hs;

  assign in_payload = (state == PAYLOAD);
  // The header state is always ready, so a valid beat there is a handshake
  assign hdr_hs = !in_payload && s_axis_tvalid;
  assign pay_hs = in_payload && s_axis_tvalid && s_axis_tready;

  // Packet framing: header beat moves to PAYLOAD unless it is also the last
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HEADER;
    end else if (hdr_hs && !s_axis_tlast) begin
      state <= PAYLOAD;
    end else if (pay_hs && s_axis_tlast) begin
      state <= HEADER;
    end
  end

  // Capture the rollover time on each header and flag discarded header-only packets
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tuser_q     <= '0;
      header_only <= 1'b0;
    end else begin
      header_only <= hdr_hs && s_axis_tlast;
      if (hdr_hs) begin
        tuser_q <= USER_WIDTH'(rollover_of(s_axis_tdata));
      end
    end
  end

`ifdef HEADER_DETACHER_OUT_REG_EN

  localparam int BUNDLE_W = USER_WIDTH + 1 + KEEP_WIDTH + DATA_WIDTH;

  logic                buf_s_ready;
  logic [BUNDLE_W-1:0] in_bundle;
  logic [BUNDLE_W-1:0] out_bundle;

  // The header is consumed here and never enters the buffer; tuser travels
  // with each payload beat so the next header may update tuser_q freely.
  assign s_axis_tready = in_payload ? buf_s_ready : 1'b1;
  assign in_bundle     = {tuser_q, s_axis_tlast, s_axis_tkeep, s_axis_tdata};

  axis_skid_buffer #(
    .WIDTH(BUNDLE_W)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (in_payload && s_axis_tvalid),
    .s_ready (buf_s_ready),
    .s_data  (in_bundle),
    .m_valid (m_axis_tvalid),
    .m_ready (m_axis_tready),
    .m_data  (out_bundle)
  );

  assign m_axis_tdata = out_bundle[DATA_WIDTH-1:0];
  assign m_axis_tkeep = out_bundle[DATA_WIDTH +: KEEP_WIDTH];
  assign m_axis_tlast = out_bundle[DATA_WIDTH + KEEP_WIDTH];
  assign m_axis_tuser = out_bundle[BUNDLE_W-1 -: USER_WIDTH];

`else

  // Zero-latency pass-through; outputs are forced to zero outside PAYLOAD so
  // the header beat never shows up and reset clears them immediately.
  assign s_axis_tready = in_payload ? m_axis_tready : 1'b1;
  assign m_axis_tvalid = in_payload && s_axis_tvalid;
  assign m_axis_tdata  = in_payload ? s_axis_tdata : '0;
  assign m_axis_tkeep  = in_payload ? s_axis_tkeep : '0;
  assign m_axis_tlast  = in_payload && s_axis_tlast;
  assign m_axis_tuser  = tuser_q;

`endif

endmodule

// File: tb/tb_header_detacher.sv
// Self-checking bench for header_detacher: reset values, a table of
// hand-picked packets (including header-only and back-to-back packets),
// 100 random packets under random backpressure checked against a
// packet-level model, and a reset in the middle of a packet.
module tb_header_detacher;

  localparam int DW = 128;
  localparam int KW = 16;
  localparam int UW = 32;

  logic          clk;
  logic          rst_n;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tlast;
  logic [KW-1:0] s_axis_tkeep;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tlast;
  logic [KW-1:0] m_axis_tkeep;
  logic [UW-1:0] m_axis_tuser;
  logic          header_only;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  header_detacher #(
    .DATA_WIDTH(DW),
    .KEEP_WIDTH(KW),
    .USER_WIDTH(UW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tkeep  (s_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tuser  (m_axis_tuser),
    .header_only   (header_only)
  );

  typedef struct {
    logic [127:0] data;
    logic [15:0]  keep;
    logic         last;
    logic [31:0]  user;
  } beat_t;

  typedef struct {
    logic [127:0] data;
    logic [15:0]  keep;
    logic         last;
    logic         is_payload;
    logic [31:0]  exp_user;
  } vec_t;

  int    checks = 0;
  int    passed = 0;
  beat_t out_q[$];
  int    out_cyc[$];
  beat_t exp_q[$];
  int    cyc = 0;
  int    ho_count = 0;
  logic  ready_random = 1'b0;
  logic  stall_prev = 1'b0;
  beat_t prev_b;

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Header layout: [31:0] magic, [63:32] sequence, [95:64] rollover, [127:96] reserved
  function automatic logic [127:0] make_header(input logic [31:0] roll, input logic [31:0] seq);
    return {32'hA5A5_0000, roll, seq, 32'h5454_0001};
  endfunction

  // Output monitor: records accepted beats and checks stability while stalled
  always @(negedge clk) begin
    beat_t cur;
    cyc++;
    cur.data = m_axis_tdata;
    cur.keep = m_axis_tkeep;
    cur.last = m_axis_tlast;
    cur.user = m_axis_tuser;
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check_output("stall_valid", 128'(m_axis_tvalid), 128'd1);
        check_output("stall_data", cur.data, prev_b.data);
        check_output("stall_ctrl", {79'd0, cur.user, cur.keep, cur.last},
                     {79'd0, prev_b.user, prev_b.keep, prev_b.last});
      end
      if (m_axis_tvalid && m_axis_tready) begin
        out_q.push_back(cur);
        out_cyc.push_back(cyc);
      end
      if (header_only) ho_count++;
      stall_prev = m_axis_tvalid && !m_axis_tready;
      prev_b = cur;
    end
  end

  // Downstream ready: constant 1 or 50% random toggling
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_axis_tready = ready_random ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Drive one beat and hold it until it is accepted; valid stays high afterwards
  task automatic apply_stimulus(input logic [127:0] d, input logic [15:0] k, input logic l);
    int waited;
    waited = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    @(negedge clk);
    while (!s_axis_tready && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    if (!s_axis_tready) check_output("input_accept_timeout", 128'd0, 128'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s_axis_tvalid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (out_q.size() < exp_q.size() && n < budget) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic compare_streams(input string tag);
    check_output({tag, "_beat_count"}, 128'(out_q.size()), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      check_output({tag, "_data"}, out_q[i].data, exp_q[i].data);
      check_output({tag, "_keep"}, 128'(out_q[i].keep), 128'(exp_q[i].keep));
      check_output({tag, "_last"}, 128'(out_q[i].last), 128'(exp_q[i].last));
      check_output({tag, "_tuser"}, 128'(out_q[i].user), 128'(exp_q[i].user));
    end
    out_q.delete();
    out_cyc.delete();
    exp_q.delete();
  endtask

  initial begin
    vec_t        tbl[10];
    int          ho_base;
    int          exp_ho;
    int          n;
    logic [31:0] roll;
    beat_t       x;

    rst_n         = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = 1'b0;

    // Reset values
    #12;
    check_output("reset_tvalid", 128'(m_axis_tvalid), 128'd0);
    check_output("reset_tdata", m_axis_tdata, 128'd0);
    check_output("reset_tkeep", 128'(m_axis_tkeep), 128'd0);
    check_output("reset_tlast", 128'(m_axis_tlast), 128'd0);
    check_output("reset_tuser", 128'(m_axis_tuser), 128'd0);
    check_output("reset_header_only", 128'(header_only), 128'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table: 3-beat packet, header-only packet, then two back-to-back packets
    tbl[0] = '{make_header(32'h1234_5678, 32'd0), 16'hFFFF, 1'b0, 1'b0, 32'd0};
    tbl[1] = '{128'hA000_0000_A111_1111_A222_2222_A333_3333, 16'hFFFF, 1'b0, 1'b1, 32'h1234_5678};
    tbl[2] = '{128'hB000_0000_B111_1111_B222_2222_B333_3333, 16'h00FF, 1'b1, 1'b1, 32'h1234_5678};
    tbl[3] = '{make_header(32'h0BAD_F00D, 32'd1), 16'h0000, 1'b1, 1'b0, 32'd0};
    tbl[4] = '{make_header(32'h0000_0001, 32'd2), 16'hFFFF, 1'b0, 1'b0, 32'd0};
    tbl[5] = '{128'hC0C0_C0C0_C1C1_C1C1_C2C2_C2C2_C3C3_C3C3, 16'hFFFF, 1'b0, 1'b1, 32'h0000_0001};
    tbl[6] = '{128'hD0D0_D0D0_D1D1_D1D1_D2D2_D2D2_D3D3_D3D3, 16'h0F0F, 1'b1, 1'b1, 32'h0000_0001};
    tbl[7] = '{make_header(32'hFFFF_FFFF, 32'd3), 16'hFFFF, 1'b0, 1'b0, 32'd0};
    tbl[8] = '{128'hE0E0_E0E0_E1E1_E1E1_E2E2_E2E2_E3E3_E3E3, 16'hFFFF, 1'b0, 1'b1, 32'hFFFF_FFFF};
    tbl[9] = '{128'hF0F0_F0F0_F1F1_F1F1_F2F2_F2F2_F3F3_F3F3, 16'h0001, 1'b1, 1'b1, 32'hFFFF_FFFF};

    ho_base = ho_count;
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(tbl[i].data, tbl[i].keep, tbl[i].last);
      if (tbl[i].is_payload) begin
        x.data = tbl[i].data;
        x.keep = tbl[i].keep;
        x.last = tbl[i].last;
        x.user = tbl[i].exp_user;
        exp_q.push_back(x);
      end
    end
    idle();
    wait_drain(200);

    // Input beats were back-to-back, so output spacing only skips header cycles
    if (out_cyc.size() >= 6) begin
      check_output("gap_A_B", 128'(out_cyc[1] - out_cyc[0]), 128'd1);
      check_output("gap_B_C", 128'(out_cyc[2] - out_cyc[1]), 128'd3);
      check_output("gap_C_D", 128'(out_cyc[3] - out_cyc[2]), 128'd1);
      check_output("gap_D_E", 128'(out_cyc[4] - out_cyc[3]), 128'd2);
      check_output("gap_E_F", 128'(out_cyc[5] - out_cyc[4]), 128'd1);
    end else begin
      check_output("gap_beat_count", 128'(out_cyc.size()), 128'd6);
    end
    check_output("table_header_only_pulses", 128'(ho_count - ho_base), 128'd1);
    compare_streams("table");

    // Random packets under random backpressure against a packet-level model
    ready_random = 1'b1;
    ho_base = ho_count;
    exp_ho = 0;
    for (int p = 0; p < 100; p++) begin
      n = $urandom_range(0, 4);
      roll = $urandom;
      apply_stimulus(make_header(roll, p), 16'($urandom), n == 0);
      if (n == 0) exp_ho++;
      for (int b = 0; b < n; b++) begin
        x.data = {$urandom, $urandom, $urandom, $urandom};
        x.keep = 16'($urandom);
        x.last = (b == n - 1);
        x.user = roll;
        exp_q.push_back(x);
        apply_stimulus(x.data, x.keep, x.last);
      end
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();
    wait_drain(3000);
    ready_random = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_output("random_header_only_pulses", 128'(ho_count - ho_base), 128'(exp_ho));
    compare_streams("random");

    // Reset asserted while the second payload beat is on the input
    apply_stimulus(make_header(32'h55AA_55AA, 32'd7), 16'hFFFF, 1'b0);
    apply_stimulus(128'h1111_2222_3333_4444_5555_6666_7777_8888, 16'hFFFF, 1'b0);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000;
    s_axis_tlast  = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_output("midreset_tvalid", 128'(m_axis_tvalid), 128'd0);
    check_output("midreset_tdata", m_axis_tdata, 128'd0);
    check_output("midreset_tkeep", 128'(m_axis_tkeep), 128'd0);
    check_output("midreset_tlast", 128'(m_axis_tlast), 128'd0);
    check_output("midreset_tuser", 128'(m_axis_tuser), 128'd0);
    s_axis_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_q.delete();
    out_cyc.delete();
    exp_q.delete();
    ho_base = ho_count;

    apply_stimulus(make_header(32'hCAFE_BABE, 32'd9), 16'hFFFF, 1'b0);
    x.data = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    x.keep = 16'h0FF0;
    x.last = 1'b1;
    x.user = 32'hCAFE_BABE;
    exp_q.push_back(x);
    apply_stimulus(x.data, x.keep, x.last);
    idle();
    wait_drain(50);
    check_output("post_reset_header_only", 128'(ho_count - ho_base), 128'd0);
    compare_streams("post_reset");

    $display("[TB] %0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
